// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: line sync, start detect, framing, hold register
// Decisions are taken only on sample_tick edges; rx_ack is honoured on every clk edge.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx_datain,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       checkstop,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          overrun_error_q, overrun_error_d;
  logic          checkstop_q, checkstop_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d         = state_q;
    sync1_d         = rx_datain;
    rx_s_d          = sync1_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_data_d       = rx_data_q;
    data_valid_d    = data_valid_q;
    frame_error_d   = 1'b0;
    overrun_error_d = overrun_error_q;

    if (rx_ack) begin
      data_valid_d    = 1'b0;
      overrun_error_d = 1'b0;
    end

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            tick_cnt_d = '0;
            state_d    = START;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == HALF_M1) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = DATA;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == FULL_M1) begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              tick_cnt_d = '0;
              state_d    = STOP;
            end
          end
        end
        STOP: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == FULL_M1) begin
            if (rx_s_q) begin
              // A simultaneous ack frees the holding register, so the load wins.
              if (!data_valid_q || rx_ack) begin
                rx_data_d    = shift_q >> (8 - DATA_BITS);
                data_valid_d = 1'b1;
              end else begin
                overrun_error_d = 1'b1;
              end
              state_d = IDLE;
            end else begin
              frame_error_d = 1'b1;
              state_d       = BRK;
            end
          end
        end
        BRK: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    checkstop_d = (state_d == STOP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b1;
      rx_s_q          <= 1'b1;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      data_valid_q    <= 1'b0;
      frame_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;
      checkstop_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      rx_s_q          <= rx_s_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_data_q       <= rx_data_d;
      data_valid_q    <= data_valid_d;
      frame_error_q   <= frame_error_d;
      overrun_error_q <= overrun_error_d;
      checkstop_q     <= checkstop_d;
      busy_q          <= busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_valid    = data_valid_q;
  assign frame_error   = frame_error_q;
  assign overrun_error = overrun_error_q;
  assign checkstop     = checkstop_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed and randomized frames against a byte-level receiver model
module tb_uart_rx_ctrl;

  localparam int TDIV   = 4;
  localparam int BITCLK = 8 * TDIV;

  logic       clk;
  logic       rst_n;
  logic       sample_tick;
  logic       rx_datain;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       frame_error;
  logic       overrun_error;
  logic       checkstop;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int   cs_ticks = 0, busy_ticks = 0, fe_cnt = 0, stop_events = 0;
  logic dv_at_stop = 0, fe_at_stop = 0;

  logic [7:0] exp_data;
  logic       exp_dv, exp_ov;

  uart_rx_ctrl #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_datain(rx_datain),
    .rx_ack(rx_ack), .rx_data(rx_data), .data_valid(data_valid),
    .frame_error(frame_error), .overrun_error(overrun_error),
    .checkstop(checkstop), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  // Observes each edge after it settles; *_p hold the value before that edge.
  initial begin
    logic cs_p, busy_p;
    cs_p = 1'b0;
    busy_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sample_tick && cs_p) cs_ticks++;
      if (sample_tick && busy_p) busy_ticks++;
      if (frame_error) fe_cnt++;
      if (cs_p && !checkstop) begin
        stop_events++;
        dv_at_stop = data_valid;
        fe_at_stop = frame_error;
      end
      cs_p = checkstop;
      busy_p = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_datain = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_datain = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    rx_datain = stop;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    exp_dv = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic ack_at_stop();
    int   n;
    logic csp;
    n = 0;
    csp = 1'b0;
    for (int i = 0; i < 4000 && n < 7; i++) begin
      @(posedge clk);
      #1;
      if (sample_tick && csp) n++;
      csp = checkstop;
    end
    check("ack_sync_stop_ticks", n, 7);
    for (int i = 0; i < 3 * TDIV; i++) begin
      @(negedge clk);
      #1;
      if (sample_tick) begin
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        break;
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same_edge);
    if (stop_ok) begin
      if (!exp_dv || ack_same_edge) begin
        exp_data = b;
        exp_dv = 1'b1;
        if (ack_same_edge) exp_ov = 1'b0;
      end else begin
        exp_ov = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rx_data"}, rx_data, exp_data);
    check({tag, "_data_valid"}, data_valid, exp_dv);
    check({tag, "_overrun"}, overrun_error, exp_ov);
  endtask

  task automatic idle_gap();
    repeat (40 + $urandom_range(0, 7)) @(negedge clk);
  endtask

  initial begin
    int cs0, fe0, se0, bt0;
    logic [7:0] b;
    logic ok, ack;

    rst_n = 1'b0;
    rx_datain = 1'b1;
    rx_ack = 1'b0;
    exp_data = 8'h00;
    exp_dv = 1'b0;
    exp_ov = 1'b0;
    repeat (4) @(negedge clk);
    check_state("reset");
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_checkstop", checkstop, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle_gap();

    // Good frame 0xA5
    cs0 = cs_ticks; fe0 = fe_cnt; se0 = stop_events;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_state("good");
    check("good_dv_at_stop_edge", dv_at_stop, 1'b1);
    check("good_checkstop_ticks", cs_ticks - cs0, 8);
    check("good_fe_pulses", fe_cnt - fe0, 0);
    check("good_stop_events", stop_events - se0, 1);
    check("good_busy_after", busy, 1'b0);
    idle_gap();
    pulse_ack();
    check_state("ack1");

    // False start: line low for 2 ticks
    bt0 = busy_ticks; fe0 = fe_cnt;
    @(negedge clk);
    rx_datain = 1'b0;
    repeat (2 * TDIV) @(negedge clk);
    rx_datain = 1'b1;
    repeat (3 * BITCLK) @(negedge clk);
    check("false_start_busy_ticks", busy_ticks - bt0, 4);
    check("false_start_busy", busy, 1'b0);
    check("false_start_fe", fe_cnt - fe0, 0);
    check_state("false_start");

    // Framing error 0x3C, line held low afterwards
    fe0 = fe_cnt; se0 = stop_events;
    send_frame(8'h3C, 1'b0);
    check("ferr_fe_at_stop_edge", fe_at_stop, 1'b1);
    repeat (3 * BITCLK) @(negedge clk);
    check("ferr_busy_while_low", busy, 1'b1);
    check("ferr_stop_events", stop_events - se0, 1);
    check("ferr_fe_pulses", fe_cnt - fe0, 1);
    rx_datain = 1'b1;
    repeat (3 * TDIV) @(negedge clk);
    check("ferr_busy_after_high", busy, 1'b0);
    check_state("ferr");
    idle_gap();

    // Overrun
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle_gap();
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    check_state("overrun");
    idle_gap();
    pulse_ack();
    check_state("overrun_ack");

    // Ack collision: 0x11 held, ack on the stop-sample edge of 0x55
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle_gap();
    fork
      send_frame(8'h55, 1'b1);
      ack_at_stop();
    join
    model_frame(8'h55, 1'b1, 1'b1);
    check_state("collision");
    idle_gap();

    // Reset during data bit 3
    @(negedge clk);
    rx_datain = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_datain = i[0];
      repeat (BITCLK) @(negedge clk);
    end
    rx_datain = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_data = 8'h00; exp_dv = 1'b0; exp_ov = 1'b0;
    check_state("midreset");
    check("midreset_busy", busy, 1'b0);
    check("midreset_checkstop", checkstop, 1'b0);
    check("midreset_frame_error", frame_error, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1, 1'b0);
    check_state("after_reset");
    idle_gap();

    // Randomized frames
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      ack = ($urandom_range(0, 1) == 1);
      if (ack) pulse_ack();
      cs0 = cs_ticks; fe0 = fe_cnt; se0 = stop_events;
      send_frame(b, ok);
      model_frame(b, ok, 1'b0);
      rx_datain = 1'b1;
      check_state($sformatf("rand%0d", k));
      check($sformatf("rand%0d_cs_ticks", k), cs_ticks - cs0, 8);
      check($sformatf("rand%0d_fe_pulses", k), fe_cnt - fe0, ok ? 0 : 1);
      check($sformatf("rand%0d_stop_events", k), stop_events - se0, 1);
      check($sformatf("rand%0d_dv_at_stop", k), dv_at_stop, exp_dv);
      idle_gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
